// File: rtl/md_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide scheduler.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {StIdle, StBusy} md_state_t;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  function automatic logic is_muldiv(md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO arithmetic: returns {hi, lo} for mult/multu/div/divu.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] result_o
);

  logic [31:0] rs_mag, rt_mag, dvd, dvs, dvs_safe, uq, ur, sq, sr;
  logic [63:0] prod_s, prod_u;

  always_comb begin
    rs_mag   = rs_i[31] ? -rs_i : rs_i;
    rt_mag   = rt_i[31] ? -rt_i : rt_i;
    // One unsigned divider serves both flavours; signed works on magnitudes.
    dvd      = (op_i == MD_DIV) ? rs_mag : rs_i;
    dvs      = (op_i == MD_DIV) ? rt_mag : rt_i;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    uq       = dvd / dvs_safe;
    ur       = dvd % dvs_safe;
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, sign positive.
    sq       = (rs_i[31] ^ rt_i[31]) ? -uq : uq;
    sr       = rs_i[31] ? -ur : ur;
    prod_s   = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    prod_u   = {32'd0, rs_i} * {32'd0, rt_i};

    result_o = '0;
    unique case (op_i)
      MD_MULT:  result_o = prod_s;
      MD_MULTU: result_o = prod_u;
      MD_DIV:   result_o = (rt_i == 32'd0) ? {rs_i, 32'hFFFF_FFFF} : {sr, sq};
      MD_DIVU:  result_o = (rt_i == 32'd0) ? {rs_i, 32'hFFFF_FFFF} : {ur, uq};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle HI/LO scheduler: runs mult/div for a fixed latency, commits HI/LO,
// and requests decode stalls for HI/LO instructions while an op is in flight.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        d_is_md_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_op_t          op;
  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     pend_q, pend_d, arith_res;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;
  logic            accept;

  assign op     = md_op_t'(md_op_i);
  assign accept = start_i & is_muldiv(op);

  md_arith u_arith (
    .op_i     (op),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .result_o (arith_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: if (cnt_q == CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pend_d = arith_res;
          cnt_d  = (op == MD_MULT || op == MD_MULTU) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        end else if (start_i && op == MD_MTHI) begin
          hi_d = rs_i;
        end else if (start_i && op == MD_MTLO) begin
          lo_d = rs_i;
        end
      end
      // Starts while busy are dropped: only the countdown and commit happen here.
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d   = pend_q[63:32];
          lo_d   = pend_q[31:0];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    busy_o  = (state_q == StBusy);
    stall_o = d_is_md_i & ((state_q == StBusy) | accept);
    done_o  = done_q;
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage pipeline. It accepts a HI/LO operation issued from the EX stage, runs it for a fixed multi-cycle latency, and commits the result to its HI/LO registers. While an operation is in flight it tells the hazard unit to stall any decode-stage instruction that touches HI/LO. `mfhi`/`mflo` read the committed `hi_o`/`lo_o` values.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start_i` input, 1 bit: EX-stage instruction is a HI/LO op; sampled each rising edge.
- `md_op_i` input, 3 bits: op code (encoding in package).
- `rs_i` input, 32 bits: forwarded rs operand from EX (MFRSE).
- `rt_i` input, 32 bits: forwarded rt operand from EX (MFRTE).
- `d_is_md_i` input, 1 bit: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy_o` output, 1 bit: operation in flight.
- `stall_o` output, 1 bit: stall request to the hazard unit (combinational).
- `done_o` output, 1 bit: one-cycle pulse in the cycle after HI/LO commit.
- `hi_o` output, 32 bits: committed HI.
- `lo_o` output, 32 bits: committed LO.

## Operation
- States are IDLE and BUSY. Reset value of every output and register is 0, and the state is IDLE.
- In IDLE, `start_i` with MULT/MULTU/DIV/DIVU:
  - compute the result from `rs_i`/`rt_i` into pending registers;
  - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to BUSY.
- In IDLE, `start_i` with MTHI/MTLO: write `rs_i` to HI or LO at that edge. The state stays IDLE and `busy_o` stays 0.
- `start_i` with MD_NONE is ignored.
- In BUSY, the counter decrements every edge. At the edge where the counter equals 1:
  - commit the pending result to HI/LO;
  - set `done_o` for one cycle;
  - return to IDLE.
- `start_i` in BUSY is an illegal input: it is ignored, HI/LO are not modified, and the bench asserts it never occurs.
- `stall_o` = `d_is_md_i & (busy_o | (start_i & md_op_i ∈ {MULT,MULTU,DIV,DIVU}))`.
- Arithmetic:
  - `mult`: signed 64-bit product, `{hi,lo}`.
  - `multu`: unsigned 64-bit product.
  - `div`: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - `divu`: unsigned quotient and remainder.
  - Divide by zero (both div and divu): lo = `32'hFFFFFFFF`, hi = `rs_i`.
  - Signed `32'h80000000 / 32'hFFFFFFFF`: lo = `32'h80000000`, hi = 0.
- Reset asserted mid-operation clears the state, counter, pending result, HI and LO immediately. No commit and no `done_o` follow.

## Timing
- Start sampled at edge T with N = configured cycles:
  - `busy_o` is high from T to T+N.
  - HI/LO update at edge T+N.
  - `busy_o` is low and `done_o` is high in the cycle after T+N.
- A back-to-back start is accepted at edge T+N+1 at the earliest (the cycle `busy_o` is low).
- MTHI/MTLO latency is 1: the new value is visible on `hi_o`/`lo_o` in the cycle after the edge.
- `stall_o` is combinational and valid in the same cycle as its inputs. It is never asserted when `d_is_md_i` = 0.
- `hi_o`/`lo_o` are registered and hold old values throughout BUSY.

## Structure
- Package `md_pkg`:
  - `md_op_t` encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default cycle constants.
  - Helper predicate `is_muldiv(op)`.
- Sub-module `md_arith`: purely combinational; takes op, rs and rt, returns the 64-bit `{hi,lo}` result including the divide-by-zero and overflow rules.
- `md_sched` holds the FSM, counter, pending registers and HI/LO.

## Test plan
- MULT with rs=`FFFFFFFD` (-3), rt=5:
  - `busy_o` high for 5 cycles;
  - then hi=`FFFFFFFF`, lo=`FFFFFFF1`;
  - `done_o` pulses once.
- MULTU with rs=`FFFFFFFF`, rt=2 → hi=1, lo=`FFFFFFFE`.
- DIV with rs=-7, rt=2 → after 10 busy cycles, lo=`FFFFFFFD`, hi=`FFFFFFFF`.
- DIVU with rt=0, rs=`1234` → lo=`FFFFFFFF`, hi=`1234`.
- Stall during DIV: hold `d_is_md_i`=1 from the start cycle → `stall_o` high in the start cycle plus 10 busy cycles, low in the first idle cycle.
- `d_is_md_i`=0 throughout → `stall_o` stays 0.
- MTHI rs=`CAFE` while IDLE → hi=`CAFE` next cycle, `busy_o` never rises.
- Reset low at busy cycle 4 of a DIV → all outputs 0 immediately; no `done_o` and no HI/LO change after release.
